// File: rtl/board_frame_rx.sv
// board_frame_rx
// Receives six-byte game-board frames from a strobed parallel pin link:
//   HEADER, board lo, board hi, cells lo, cells hi, checksum (XOR of payload).
// Payload is collected into shadow registers. The visible board/cell maps
// update only when a complete frame passes the checksum and ownership checks.
// An idle gap of TIMEOUT cycles inside a frame aborts it. Rejections and
// aborts are counted in a saturating 8-bit error counter.

module board_frame_rx #(
    parameter logic [7:0]  HEADER  = 8'hA5,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  pin_data,
    input  logic        pin_strobe,
    output logic [15:0] gameboard,
    output logic [15:0] player_cells,
    output logic        frame_valid,
    output logic        frame_error,
    output logic [7:0]  error_count
);

    // The gap counter holds the number of strobe-less cycles seen so far.
    // A timeout fires on the edge where it would step onto TIMEOUT.
    localparam logic [7:0] LP_GAP_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_BLO  = 3'd1,
        ST_BHI  = 3'd2,
        ST_CLO  = 3'd3,
        ST_CHI  = 3'd4,
        ST_CHK  = 3'd5
    } state_t;

    // XOR of the four payload bytes, compared against the checksum byte.
    function automatic logic [7:0] payload_xor(input logic [15:0] board,
                                               input logic [15:0] cells);
        return board[7:0] ^ board[15:8] ^ cells[7:0] ^ cells[15:8];
    endfunction

    // A player may only own a cell that is also marked occupied.
    function automatic logic ownership_ok(input logic [15:0] board,
                                          input logic [15:0] cells);
        return ((cells & ~board) == 16'h0000);
    endfunction

    // Error counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        logic [7:0] result;
        if (value == 8'hFF) begin
            result = 8'hFF;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

    state_t      r_state;
    logic [15:0] r_board_sh;
    logic [15:0] r_cells_sh;
    logic [7:0]  r_gap;
    logic [15:0] r_gameboard;
    logic [15:0] r_player_cells;
    logic        r_frame_valid;
    logic        r_frame_error;
    logic [7:0]  r_error_count;

    logic        w_in_frame;
    logic        w_timeout;
    logic        w_frame_ok;

    // Frame-level decisions: are we mid-frame, has the gap expired, would the
    // byte now on the pins complete a good frame.
    always_comb begin
        w_in_frame = 1'b0;
        w_timeout  = 1'b0;
        w_frame_ok = 1'b0;
        if (r_state != ST_IDLE) begin
            w_in_frame = 1'b1;
        end else begin
            w_in_frame = 1'b0;
        end
        if (w_in_frame && !pin_strobe && (r_gap == LP_GAP_LAST)) begin
            w_timeout = 1'b1;
        end else begin
            w_timeout = 1'b0;
        end
        if ((payload_xor(r_board_sh, r_cells_sh) == pin_data) &&
            ownership_ok(r_board_sh, r_cells_sh)) begin
            w_frame_ok = 1'b1;
        end else begin
            w_frame_ok = 1'b0;
        end
    end

    // Receive FSM with shadow capture, gap timer, output maps and status pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_board_sh     <= 16'h0000;
            r_cells_sh     <= 16'h0000;
            r_gap          <= 8'h00;
            r_gameboard    <= 16'h0000;
            r_player_cells <= 16'h0000;
            r_frame_valid  <= 1'b0;
            r_frame_error  <= 1'b0;
            r_error_count  <= 8'h00;
        end else begin
            // Status outputs are single-cycle pulses unless set below.
            r_frame_valid <= 1'b0;
            r_frame_error <= 1'b0;

            if (!w_in_frame) begin
                // Idle: hunt for the header, ignore anything else silently.
                r_gap <= 8'h00;
                if (pin_strobe && (pin_data == HEADER)) begin
                    r_state <= ST_BLO;
                end else begin
                    r_state <= ST_IDLE;
                end
            end else if (!pin_strobe) begin
                // Mid-frame with no byte: run the gap timer, abort on expiry.
                if (w_timeout) begin
                    r_state       <= ST_IDLE;
                    r_gap         <= 8'h00;
                    r_board_sh    <= 16'h0000;
                    r_cells_sh    <= 16'h0000;
                    r_frame_error <= 1'b1;
                    r_error_count <= sat_inc(r_error_count);
                end else begin
                    r_gap <= r_gap + 8'd1;
                end
            end else begin
                // Mid-frame byte: every byte is data here, even one equal to HEADER.
                r_gap <= 8'h00;
                case (r_state)
                    ST_BLO: begin
                        r_board_sh[7:0] <= pin_data;
                        r_state         <= ST_BHI;
                    end
                    ST_BHI: begin
                        r_board_sh[15:8] <= pin_data;
                        r_state          <= ST_CLO;
                    end
                    ST_CLO: begin
                        r_cells_sh[7:0] <= pin_data;
                        r_state         <= ST_CHI;
                    end
                    ST_CHI: begin
                        r_cells_sh[15:8] <= pin_data;
                        r_state          <= ST_CHK;
                    end
                    ST_CHK: begin
                        r_state <= ST_IDLE;
                        if (w_frame_ok) begin
                            r_gameboard    <= r_board_sh;
                            r_player_cells <= r_cells_sh;
                            r_frame_valid  <= 1'b1;
                        end else begin
                            r_frame_error <= 1'b1;
                            r_error_count <= sat_inc(r_error_count);
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign gameboard    = r_gameboard;
    assign player_cells = r_player_cells;
    assign frame_valid  = r_frame_valid;
    assign frame_error  = r_frame_error;
    assign error_count  = r_error_count;

endmodule

// File: tb/tb_board_frame_rx.sv
// Testbench for board_frame_rx: directed scenarios plus randomized frames,
// every cycle checked against a byte-count/idle-count reference model.

module tb_board_frame_rx;

    localparam int TMO = 255;

    logic        clk;
    logic        reset;
    logic [7:0]  pin_data;
    logic        pin_strobe;
    logic [15:0] gameboard;
    logic [15:0] player_cells;
    logic        frame_valid;
    logic        frame_error;
    logic [7:0]  error_count;

    int n_total = 0;
    int n_bad   = 0;

    // reference model state
    int          m_cnt;      // 0 = waiting for header, k = k bytes of frame seen
    int          m_idle;     // strobe-less cycles since last in-frame byte
    logic [7:0]  m_bytes [4];
    logic [15:0] m_gb;
    logic [15:0] m_pc;
    logic        m_valid;
    logic        m_err;
    int          m_ec;

    board_frame_rx #(.HEADER(8'hA5), .TIMEOUT(TMO)) dut (
        .clk          (clk),
        .reset        (reset),
        .pin_data     (pin_data),
        .pin_strobe   (pin_strobe),
        .gameboard    (gameboard),
        .player_cells (player_cells),
        .frame_valid  (frame_valid),
        .frame_error  (frame_error),
        .error_count  (error_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Model: what a correct receiver does with one clock of input.
    task automatic model_step(input logic r, input logic s, input logic [7:0] d);
        logic [15:0] board;
        logic [15:0] cells;
        m_valid = 1'b0;
        m_err   = 1'b0;
        if (r) begin
            m_cnt = 0; m_idle = 0; m_gb = 16'h0; m_pc = 16'h0; m_ec = 0;
        end else if (s) begin
            m_idle = 0;
            if (m_cnt == 0) begin
                if (d == 8'hA5) m_cnt = 1;
            end else if (m_cnt < 5) begin
                m_bytes[m_cnt-1] = d;
                m_cnt++;
            end else begin
                board = {m_bytes[1], m_bytes[0]};
                cells = {m_bytes[3], m_bytes[2]};
                if (d == (m_bytes[0] ^ m_bytes[1] ^ m_bytes[2] ^ m_bytes[3]) &&
                    (cells & ~board) == 16'h0) begin
                    m_gb = board; m_pc = cells; m_valid = 1'b1;
                end else begin
                    m_err = 1'b1;
                    if (m_ec < 255) m_ec++;
                end
                m_cnt = 0;
            end
        end else if (m_cnt != 0) begin
            m_idle++;
            if (m_idle == TMO) begin
                m_err = 1'b1;
                if (m_ec < 255) m_ec++;
                m_cnt = 0;
                m_idle = 0;
            end
        end else begin
            m_idle = 0;
        end
    endtask

    // One clock: drive, advance model, sample after the edge and compare.
    task automatic cyc(input logic r, input logic s, input logic [7:0] d);
        reset = r; pin_strobe = s; pin_data = d;
        @(posedge clk);
        model_step(r, s, d);
        #1;
        chk("gameboard", 32'(gameboard), 32'(m_gb));
        chk("player_cells", 32'(player_cells), 32'(m_pc));
        chk("frame_valid", 32'(frame_valid), 32'(m_valid));
        chk("frame_error", 32'(frame_error), 32'(m_err));
        chk("error_count", 32'(error_count), 32'(m_ec));
        chk("valid_err_excl", 32'(frame_valid & frame_error), 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00);
    endtask

    task automatic send6(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                         input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5);
        cyc(1'b0, 1'b1, b0); cyc(1'b0, 1'b1, b1); cyc(1'b0, 1'b1, b2);
        cyc(1'b0, 1'b1, b3); cyc(1'b0, 1'b1, b4); cyc(1'b0, 1'b1, b5);
    endtask

    initial begin
        logic [15:0] rb;
        logic [15:0] rc;
        logic [7:0]  ck;
        logic [7:0]  fb [6];
        int          gap;

        reset = 1'b1; pin_strobe = 1'b0; pin_data = 8'h00;
        m_cnt = 0; m_idle = 0; m_gb = 16'h0; m_pc = 16'h0; m_ec = 0;
        m_valid = 1'b0; m_err = 1'b0;
        for (int i = 0; i < 4; i++) m_bytes[i] = 8'h00;

        // reset state, with a strobe forced during reset
        cyc(1'b1, 1'b1, 8'hA5);
        cyc(1'b1, 1'b0, 8'h00);
        chk("rst_gameboard", 32'(gameboard), 32'h0);
        chk("rst_error_count", 32'(error_count), 32'h0);
        idle(2);

        // good frame
        send6(8'hA5, 8'h34, 8'h12, 8'h04, 8'h00, 8'h22);
        chk("good_gb", 32'(gameboard), 32'h1234);
        chk("good_pc", 32'(player_cells), 32'h0004);
        chk("good_valid", 32'(frame_valid), 32'h1);
        idle(1);
        chk("good_valid_1cyc", 32'(frame_valid), 32'h0);

        // bad checksum
        send6(8'hA5, 8'h34, 8'h12, 8'h04, 8'h00, 8'h23);
        chk("badck_err", 32'(frame_error), 32'h1);
        chk("badck_cnt", 32'(error_count), 32'h1);
        chk("badck_gb", 32'(gameboard), 32'h1234);
        idle(1);

        // ownership violation with a correct checksum
        send6(8'hA5, 8'h00, 8'h00, 8'h01, 8'h00, 8'h01);
        chk("own_err", 32'(frame_error), 32'h1);
        chk("own_pc", 32'(player_cells), 32'h0004);
        idle(1);

        // timeout: 255 idle cycles after the first payload byte
        cyc(1'b0, 1'b1, 8'hA5); cyc(1'b0, 1'b1, 8'h34);
        idle(TMO);
        chk("tmo_err", 32'(frame_error), 32'h1);
        chk("tmo_cnt", 32'(error_count), 32'h3);
        send6(8'hA5, 8'h34, 8'h12, 8'h04, 8'h00, 8'h22);
        chk("tmo_after_valid", 32'(frame_valid), 32'h1);

        // longest allowed gap: 254 idle cycles then the byte is accepted
        cyc(1'b0, 1'b1, 8'hA5); cyc(1'b0, 1'b1, 8'h0F);
        idle(TMO - 1);
        cyc(1'b0, 1'b1, 8'h00); cyc(1'b0, 1'b1, 8'h03);
        cyc(1'b0, 1'b1, 8'h00); cyc(1'b0, 1'b1, 8'h0C);
        chk("gap_edge_valid", 32'(frame_valid), 32'h1);
        chk("gap_edge_gb", 32'(gameboard), 32'h000F);

        // noise then an embedded header byte as payload
        cyc(1'b0, 1'b1, 8'h00); cyc(1'b0, 1'b1, 8'hFF);
        send6(8'hA5, 8'hA5, 8'h00, 8'h00, 8'h00, 8'hA5);
        chk("embed_gb", 32'(gameboard), 32'h00A5);
        chk("embed_pc", 32'(player_cells), 32'h0000);
        chk("embed_valid", 32'(frame_valid), 32'h1);

        // back-to-back frames with no idle cycle between them
        send6(8'hA5, 8'hFF, 8'h00, 8'h0F, 8'h00, 8'hF0);
        send6(8'hA5, 8'h11, 8'h22, 8'h01, 8'h02, 8'h30);
        chk("b2b_gb", 32'(gameboard), 32'h2211);
        chk("b2b_valid", 32'(frame_valid), 32'h1);

        // saturation
        for (int i = 0; i < 260; i++) send6(8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00);
        chk("sat_cnt", 32'(error_count), 32'hFF);

        // reset mid-frame
        cyc(1'b0, 1'b1, 8'hA5); cyc(1'b0, 1'b1, 8'h34);
        cyc(1'b1, 1'b0, 8'h00);
        chk("midrst_cnt", 32'(error_count), 32'h0);
        chk("midrst_gb", 32'(gameboard), 32'h0);
        chk("midrst_err", 32'(frame_error), 32'h0);
        idle(3);
        chk("midrst_noerr", 32'(frame_error), 32'h0);
        send6(8'hA5, 8'h34, 8'h12, 8'h04, 8'h00, 8'h22);
        chk("postrst_valid", 32'(frame_valid), 32'h1);

        // randomized frames with noise, corruption, long gaps and resets
        for (int f = 0; f < 200; f++) begin
            if ($urandom_range(0, 3) == 0) cyc(1'b0, 1'b1, 8'($urandom));
            rb = 16'($urandom);
            rc = 16'($urandom) & rb;
            if ($urandom_range(0, 4) == 0) rc = rc | 16'($urandom);
            ck = rb[7:0] ^ rb[15:8] ^ rc[7:0] ^ rc[15:8];
            if ($urandom_range(0, 4) == 0) ck = ck ^ 8'($urandom_range(1, 255));
            fb[0] = 8'hA5; fb[1] = rb[7:0]; fb[2] = rb[15:8];
            fb[3] = rc[7:0]; fb[4] = rc[15:8]; fb[5] = ck;
            for (int b = 0; b < 6; b++) begin
                gap = $urandom_range(0, 3);
                if ($urandom_range(0, 39) == 0) gap = $urandom_range(TMO - 2, TMO + 1);
                idle(gap);
                if ($urandom_range(0, 99) == 0) cyc(1'b1, 1'b0, 8'h00);
                cyc(1'b0, 1'b1, fb[b]);
            end
            idle($urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
